// File: rtl/rtr_flow_ctrl_credit_tracker.sv
// ----------------------------------------------------------------------------
// rtr_flow_ctrl_credit_tracker
//   Receive side of the router credit flow-control link at one output port.
//   Registers the credit-return bus, decodes the credit VC and keeps one
//   saturating credit counter per output VC (debit on flit departure, credit
//   on returned credit).
//
// Optional feature macro:
//   RTR_CRED_TRACKER_ERROR_CHECK_EN - compiles in sticky per-VC overflow /
//   underflow error registers; when undefined error_ovc is tied to 0.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous reset, active low
//   active         in   clock-gating activity hint for the input stage
//   flow_ctrl_in   in   [0] credit valid, [vc_idx_width:1] credit VC index
//   flit_valid_in  in   a flit departs this cycle
//   flit_sel_ovc   in   one-hot VC of the departing flit
//   cred_avail_ovc out  per-VC counter > 0
//   cred_full_ovc  out  per-VC counter == buffer_size
//   error_ovc      out  sticky per-VC overflow/underflow flag
// ----------------------------------------------------------------------------
module rtr_flow_ctrl_credit_tracker #(
    parameter int unsigned num_vcs         = 4,
    parameter int unsigned buffer_size     = 8,
    parameter int unsigned flow_ctrl_type  = 0,
    parameter int unsigned reset_type      = 0,
    localparam int unsigned vc_idx_width   = (num_vcs > 1) ? $clog2(num_vcs) : 0,
    localparam int unsigned flow_ctrl_width = 1 + vc_idx_width
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       active,
    input  logic [flow_ctrl_width-1:0] flow_ctrl_in,
    input  logic                       flit_valid_in,
    input  logic [num_vcs-1:0]         flit_sel_ovc,
    output logic [num_vcs-1:0]         cred_avail_ovc,
    output logic [num_vcs-1:0]         cred_full_ovc,
    output logic [num_vcs-1:0]         error_ovc
);

    localparam int unsigned    CntW   = $clog2(buffer_size + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(buffer_size);

    // Only credit flow control with asynchronous reset is implemented.
    if ((flow_ctrl_type != 0) || (reset_type != 0)) begin : g_bad_cfg
        $error("rtr_flow_ctrl_credit_tracker: unsupported flow_ctrl_type/reset_type");
    end

    // Credit valid register; stays enabled while set so it always self-clears.
    logic valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else if (active | valid_q) begin
            valid_q <= flow_ctrl_in[0];
        end
    end

    // Registered VC index (no reset) decoded to a one-hot credit select.
    logic [num_vcs-1:0] cred_sel_ovc;

    if (num_vcs > 1) begin : g_vc_idx
        logic [vc_idx_width-1:0] vc_idx_q;

        always_ff @(posedge clk) begin
            if (active) begin
                vc_idx_q <= flow_ctrl_in[vc_idx_width:1];
            end
        end

        always_comb begin
            cred_sel_ovc = '0;
            for (int unsigned v = 0; v < num_vcs; v++) begin
                cred_sel_ovc[v] = valid_q && (vc_idx_q == vc_idx_width'(v));
            end
        end
    end else begin : g_single_vc
        assign cred_sel_ovc = valid_q;
    end

    logic [num_vcs-1:0] inc_ovc;
    logic [num_vcs-1:0] dec_ovc;

    assign inc_ovc = cred_sel_ovc;
    assign dec_ovc = {num_vcs{flit_valid_in}} & flit_sel_ovc;

    // Per-VC saturating credit counters; simultaneous inc and dec cancel.
    logic [num_vcs-1:0][CntW-1:0] cnt_q;
    logic [num_vcs-1:0][CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned v = 0; v < num_vcs; v++) begin
            if (inc_ovc[v] && !dec_ovc[v]) begin
                if (cnt_q[v] != CntMax) begin
                    cnt_d[v] = cnt_q[v] + CntW'(1);
                end
            end else if (dec_ovc[v] && !inc_ovc[v]) begin
                if (cnt_q[v] != '0) begin
                    cnt_d[v] = cnt_q[v] - CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {num_vcs{CntMax}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Status decodes straight off the counter registers.
    always_comb begin
        cred_avail_ovc = '0;
        cred_full_ovc  = '0;
        for (int unsigned v = 0; v < num_vcs; v++) begin
            cred_avail_ovc[v] = (cnt_q[v] != '0);
            cred_full_ovc[v]  = (cnt_q[v] == CntMax);
        end
    end

`ifdef RTR_CRED_TRACKER_ERROR_CHECK_EN
    // Sticky error: credit into a full counter or debit from an empty one.
    logic [num_vcs-1:0] error_q;
    logic [num_vcs-1:0] err_det;

    assign err_det = (inc_ovc & ~dec_ovc & cred_full_ovc)
                   | (dec_ovc & ~inc_ovc & ~cred_avail_ovc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_q <= '0;
        end else begin
            error_q <= error_q | err_det;
        end
    end

    assign error_ovc = error_q;
`else
    assign error_ovc = '0;
`endif

endmodule

// File: tb/tb_rtr_flow_ctrl_credit_tracker.sv
// ----------------------------------------------------------------------------
// Bench for rtr_flow_ctrl_credit_tracker (num_vcs = 4, buffer_size = 8).
// A behavioural credit model is compared against the DUT every cycle, and
// directed scenarios add literal expectations on top.
// ----------------------------------------------------------------------------
module tb_rtr_flow_ctrl_credit_tracker;

    localparam int NV  = 4;
    localparam int BUF = 8;

`ifdef RTR_CRED_TRACKER_ERROR_CHECK_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       active = 1'b1;
    logic [2:0] fc     = '0;
    logic       fv     = 1'b0;
    logic [3:0] fsel   = '0;
    logic [3:0] avail;
    logic [3:0] full;
    logic [3:0] err;

    int total = 0;
    int bad   = 0;

    rtr_flow_ctrl_credit_tracker #(
        .num_vcs     (NV),
        .buffer_size (BUF)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .active         (active),
        .flow_ctrl_in   (fc),
        .flit_valid_in  (fv),
        .flit_sel_ovc   (fsel),
        .cred_avail_ovc (avail),
        .cred_full_ovc  (full),
        .error_ovc      (err)
    );

    always #5 clk = ~clk;

    // Model: integer credit counts clamped to [0, BUF]; a credit seen on the
    // bus lands one edge later; any clamp marks the VC as errored.
    int m_cnt[NV];
    bit m_err[NV];
    bit m_pv;
    int m_pvc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NV; v++) begin
                m_cnt[v] = BUF;
                m_err[v] = 1'b0;
            end
            m_pv = 1'b0;
        end else begin
            for (int v = 0; v < NV; v++) begin
                int n;
                n = m_cnt[v] + ((m_pv && m_pvc == v) ? 1 : 0) - ((fv && fsel[v]) ? 1 : 0);
                if (n > BUF) begin
                    n = BUF;
                    m_err[v] = 1'b1;
                end else if (n < 0) begin
                    n = 0;
                    m_err[v] = 1'b1;
                end
                m_cnt[v] = n;
            end
            if (active || m_pv) m_pv = fc[0];
            if (active) m_pvc = int'(fc[2:1]);
        end
    end

    function automatic logic [3:0] exp_avail();
        logic [3:0] r;
        for (int v = 0; v < NV; v++) r[v] = (m_cnt[v] > 0);
        return r;
    endfunction

    function automatic logic [3:0] exp_full();
        logic [3:0] r;
        for (int v = 0; v < NV; v++) r[v] = (m_cnt[v] == BUF);
        return r;
    endfunction

    function automatic logic [3:0] exp_err();
        logic [3:0] r;
        for (int v = 0; v < NV; v++) r[v] = ErrEn && m_err[v];
        return r;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_avail", avail, exp_avail());
        chk("model_full",  full,  exp_full());
        chk("model_err",   err,   exp_err());
    end

    // One clock: drive inputs, take the rising edge, return on the falling edge.
    task automatic cyc(input bit cv, input int cvc, input bit f, input logic [3:0] fs);
        fc   = {2'(cvc), cv};
        fv   = f;
        fsel = fs;
        @(posedge clk);
        @(negedge clk);
        fc   = '0;
        fv   = 1'b0;
        fsel = '0;
    endtask

    typedef struct {
        bit         cv;
        int         cvc;
        bit         f;
        logic [3:0] fs;
    } vec_t;

    vec_t mix[10];

    initial begin
        mix[0] = '{1'b0, 0, 1'b1, 4'b0001};
        mix[1] = '{1'b1, 3, 1'b1, 4'b0001};
        mix[2] = '{1'b1, 1, 1'b1, 4'b1000};
        mix[3] = '{1'b1, 0, 1'b0, 4'b0000};
        mix[4] = '{1'b0, 0, 1'b1, 4'b0100};
        mix[5] = '{1'b1, 2, 1'b1, 4'b0010};
        mix[6] = '{1'b1, 2, 1'b1, 4'b0010};
        mix[7] = '{1'b0, 0, 1'b1, 4'b0010};
        mix[8] = '{1'b1, 1, 1'b0, 4'b0000};
        mix[9] = '{1'b0, 0, 1'b0, 4'b0000};

        // Reset.
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_avail", avail, 4'b1111);
        chk("rst_full",  full,  4'b1111);
        chk("rst_err",   err,   4'b0000);
        rst_n = 1'b1;

        // Drain VC2 with 8 flits, then underflow it.
        repeat (8) cyc(1'b0, 0, 1'b1, 4'b0100);
        chk("drain_avail", avail, 4'b1011);
        chk("drain_full",  full,  4'b1011);
        cyc(1'b0, 0, 1'b1, 4'b0100);
        chk("udf_avail", avail, 4'b1011);
        chk("udf_err",   err,   ErrEn ? 4'b0100 : 4'b0000);

        // Credit latency on VC2: nothing after edge N, visible after N+1.
        cyc(1'b1, 2, 1'b0, 4'b0000);
        chk("cred_lat_n",  avail, 4'b1011);
        cyc(1'b0, 0, 1'b0, 4'b0000);
        chk("cred_lat_n1", avail, 4'b1111);
        // Back-to-back credits, then one more -> VC2 count 4.
        cyc(1'b1, 2, 1'b0, 4'b0000);
        cyc(1'b1, 2, 1'b0, 4'b0000);
        cyc(1'b0, 0, 1'b0, 4'b0000);
        cyc(1'b1, 2, 1'b0, 4'b0000);
        cyc(1'b0, 0, 1'b0, 4'b0000);
        repeat (3) cyc(1'b0, 0, 1'b1, 4'b0100);
        chk("vc2_cnt4_a", avail, 4'b1111);
        cyc(1'b0, 0, 1'b1, 4'b0100);
        chk("vc2_cnt4_b", avail, 4'b1011);

        // VC1 to 5; same-VC credit and flit at one edge; VC2 credit with VC3 debit.
        repeat (3) cyc(1'b0, 0, 1'b1, 4'b0010);
        cyc(1'b1, 1, 1'b0, 4'b0000);
        cyc(1'b1, 2, 1'b1, 4'b0010);
        cyc(1'b0, 0, 1'b1, 4'b1000);
        chk("both_full", full, 4'b0001);
        chk("both_err",  err,  ErrEn ? 4'b0100 : 4'b0000);
        repeat (4) cyc(1'b0, 0, 1'b1, 4'b0010);
        chk("vc1_cnt5_a", avail, 4'b1111);
        cyc(1'b0, 0, 1'b1, 4'b0010);
        chk("vc1_cnt5_b", avail, 4'b1101);

        // Spurious credit on full VC0: saturates, sticky error.
        cyc(1'b1, 0, 1'b0, 4'b0000);
        cyc(1'b0, 0, 1'b0, 4'b0000);
        chk("ovf_full", full, 4'b0001);
        chk("ovf_err",  err,  ErrEn ? 4'b0101 : 4'b0000);
        repeat (5) cyc(1'b0, 0, 1'b0, 4'b0000);
        chk("ovf_sticky", err, ErrEn ? 4'b0101 : 4'b0000);

        // Reset with a VC3 credit in flight; it must be discarded.
        cyc(1'b1, 3, 1'b0, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_avail", avail, 4'b1111);
        chk("mid_rst_full",  full,  4'b1111);
        chk("mid_rst_err",   err,   4'b0000);
        #1 rst_n = 1'b1;
        cyc(1'b0, 0, 1'b1, 4'b1000);
        chk("rst_discard_full", full, 4'b0111);
        chk("rst_discard_err",  err,  4'b0000);

        // Credit while inactive is not captured.
        active = 1'b0;
        cyc(1'b1, 3, 1'b0, 4'b0000);
        cyc(1'b0, 0, 1'b0, 4'b0000);
        chk("inactive_full", full, 4'b0111);
        active = 1'b1;
        cyc(1'b1, 3, 1'b0, 4'b0000);
        cyc(1'b0, 0, 1'b0, 4'b0000);
        chk("active_full", full, 4'b1111);

        // Mixed traffic, model-checked each cycle.
        foreach (mix[i]) cyc(mix[i].cv, mix[i].cvc, mix[i].f, mix[i].fs);
        repeat (2) cyc(1'b0, 0, 1'b0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
